// File: rtl/mems_dac_spi_master.sv
// mems_dac_spi_master
// Write-only 24-bit SPI master for the MEMS mirror DAC. It accepts one command
// word per start pulse while idle and shifts it out MSB-first inside a SYNC
// frame: SETUP, 24 SCLK periods (low phase first, DAC samples on the falling
// edge), HOLD, then a quiet GAP before busy drops and done pulses.
// All outputs are registered and move on the same edge as the state.

module mems_dac_spi_master #(
    parameter int CLK_DIV    = 2,   // clk cycles per SCLK half-period
    parameter int GAP_CYCLES = 4    // clk cycles of sync_n high before busy drops
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] data_in,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    // The one counter times SETUP/SHIFT/HOLD half-periods and the GAP, so it
    // is sized for the larger of the two reload values. It always reloads.
    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0]       state,   state_d;
    logic [CNT_W-1:0] cnt,     cnt_d;
    logic [4:0]       bit_cnt, bit_cnt_d;

    // Bits still waiting to go out after the one currently on mosi. Bit 22 of
    // this register is always the next bit to present.
    logic [22:0]      pend,    pend_d;

    logic busy_d, done_d, sclk_d, mosi_d, sync_n_d;

    // Next-state and next-output decode for the framing FSM.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_cnt_d = bit_cnt;
        pend_d    = pend;
        busy_d    = busy;
        done_d    = 1'b0;
        sclk_d    = sclk;
        mosi_d    = mosi;
        sync_n_d  = sync_n;

        case (state)
            ST_IDLE: begin
                busy_d   = 1'b0;
                sclk_d   = 1'b1;
                mosi_d   = 1'b0;
                sync_n_d = 1'b1;
                cnt_d    = '0;
                if (start) begin
                    // Capture the whole word now; data_in is ignored from here on.
                    state_d   = ST_SETUP;
                    cnt_d     = DIV_LOAD;
                    bit_cnt_d = 5'd23;
                    pend_d    = data_in[22:0];
                    mosi_d    = data_in[23];
                    busy_d    = 1'b1;
                    sync_n_d  = 1'b0;
                end
            end

            ST_SETUP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    // First falling edge: DAC samples bit 23.
                    state_d = ST_SHIFT;
                    cnt_d   = DIV_LOAD;
                    sclk_d  = 1'b0;
                end
            end

            ST_SHIFT: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else if (!sclk) begin
                    // End of low phase: rise SCLK and present the next bit, so
                    // mosi is settled long before the next falling edge. Bit 0
                    // stays on the line through HOLD.
                    sclk_d = 1'b1;
                    cnt_d  = DIV_LOAD;
                    if (bit_cnt != 5'd0) begin
                        mosi_d = pend[22];
                        pend_d = {pend[21:0], 1'b0};
                    end
                end else if (bit_cnt == 5'd0) begin
                    // High phase of bit 0 finished: frame data complete.
                    state_d = ST_HOLD;
                    cnt_d   = DIV_LOAD;
                end else begin
                    // End of high phase: falling edge starts the next bit period.
                    bit_cnt_d = bit_cnt - 5'd1;
                    sclk_d    = 1'b0;
                    cnt_d     = DIV_LOAD;
                end
            end

            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    state_d  = ST_GAP;
                    cnt_d    = GAP_LOAD;
                    sync_n_d = 1'b1;
                    mosi_d   = 1'b0;
                end
            end

            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_ONE;
                end else begin
                    // busy falls and done pulses together; a start on this
                    // cycle is accepted because state is already IDLE.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                busy_d   = 1'b0;
                sclk_d   = 1'b1;
                mosi_d   = 1'b0;
                sync_n_d = 1'b1;
            end
        endcase
    end

    // Control state and SPI pins; reset drops the frame immediately with no done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b1;
            mosi    <= 1'b0;
            sync_n  <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_cnt <= bit_cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            sclk    <= sclk_d;
            mosi    <= mosi_d;
            sync_n  <= sync_n_d;
        end
    end

    // Pending-bit register; pure data, reloaded on every accepted start.
    always_ff @(posedge clk) begin
        pend <= pend_d;
    end

endmodule
